// File: rtl/game_flow_ctrl.sv
// Game-flow controller for the button/pong VGA games.
// It runs the round state machine, keeps the per-player scores and the ball
// budget, times the rest interval between balls, and resolves the winner.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   NEWGAME | idle between games; scores cleared, waits for an armed press
//   PLAY    | ball in motion; a miss ends the current ball
//   NEWBALL | rest interval, then an armed press serves the next ball
//   OVER    | final scores shown until the rest timer expires
//   PAUSED  | play frozen; a pause pulse resumes
module game_flow_ctrl #(
   parameter int NUM_PLAYERS = 2,
   parameter int NUM_KEYS    = 4,
   parameter int SCORE_W     = 3,
   parameter int BALLS       = 3,
   parameter int BALL_W      = 3,
   parameter int REST_TICKS  = 120,
   parameter int TMR_W       = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_KEYS-1:0]            key_n,
   input  logic                           pause_p,
   input  logic [NUM_PLAYERS-1:0]         miss,
   input  logic                           frame_tick,
   output logic [2:0]                     state,
   output logic                           stop,
   output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
   output logic [BALL_W-1:0]              balls_left,
   output logic [2:0]                     winner,
   output logic                           tie,
   output logic                           timer_busy
);

   typedef enum logic [2:0] {
      S_NEWGAME = 3'd0,
      S_PLAY    = 3'd1,
      S_NEWBALL = 3'd2,
      S_OVER    = 3'd3,
      S_PAUSED  = 3'd4
   } state_t;

   localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
   localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
   localparam logic [BALL_W-1:0]  BALLS_INIT = BALL_W'(BALLS);
   localparam logic [BALL_W-1:0]  BALL_ONE   = BALL_W'(1);
   localparam logic [TMR_W-1:0]   REST_LD    = TMR_W'(REST_TICKS);
   localparam logic [TMR_W-1:0]   TMR_ONE    = TMR_W'(1);

   state_t             cur;
   state_t             nxt;
   logic               armed;
   logic               press;
   logic               any_miss;
   logic [TMR_W-1:0]   timer;
   logic [SCORE_W-1:0] best;
   logic [3:0]         n_top;

   // A press only counts once every key has been seen released in this state,
   // so a key held across a transition cannot skip the next state.
   assign press      = armed & ~(&key_n);
   assign any_miss   = |miss;
   assign timer_busy = |timer;
   assign state      = cur;

   // State register and arming flag; arming drops on every state change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur   <= S_NEWGAME;
         armed <= 1'b0;
      end else begin
         cur <= nxt;
         if (nxt != cur)
            armed <= 1'b0;
         else if (&key_n)
            armed <= 1'b1;
      end
   end

   // Next-state decode and the freeze output.
   always_comb begin
      nxt  = cur;
      stop = 1'b1;
      case (cur)
         S_NEWGAME: if (press) nxt = S_PLAY;
         S_PLAY: begin
            stop = 1'b0;
            // a miss in the same cycle as pause takes priority
            if (any_miss)
               nxt = (balls_left == '0) ? S_OVER : S_NEWBALL;
            else if (pause_p)
               nxt = S_PAUSED;
         end
         S_NEWBALL: if (!timer_busy && press) nxt = S_PLAY;
         S_OVER:    if (!timer_busy) nxt = S_NEWGAME;
         S_PAUSED:  if (pause_p) nxt = S_PLAY;
         default:   nxt = S_NEWGAME;
      endcase
   end

   // Rest timer: loaded when a ball ends, counts frames down, frozen in pause.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         timer <= '0;
      else if (cur == S_PLAY && any_miss)
         timer <= REST_LD;
      else if (frame_tick && timer != '0 && cur != S_PAUSED)
         timer <= timer - TMR_ONE;
   end

   // Scores and ball budget; everything is cleared whenever NEWGAME is entered or held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scores     <= '0;
         balls_left <= BALLS_INIT;
      end else if (nxt == S_NEWGAME) begin
         scores     <= '0;
         balls_left <= BALLS_INIT;
      end else if (cur == S_NEWGAME && press) begin
         balls_left <= BALLS_INIT - BALL_ONE;
      end else if (cur == S_PLAY && any_miss) begin
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (!miss[i] && scores[i*SCORE_W +: SCORE_W] != SCORE_MAX)
               scores[i*SCORE_W +: SCORE_W] <= scores[i*SCORE_W +: SCORE_W] + SCORE_ONE;
         end
         if (balls_left != '0)
            balls_left <= balls_left - BALL_ONE;
      end
   end

   // Winner is the lowest-indexed top scorer; tie flags a shared maximum.
   always_comb begin
      best   = scores[SCORE_W-1:0];
      winner = '0;
      n_top  = '0;
      for (int i = 1; i < NUM_PLAYERS; i++) begin
         if (scores[i*SCORE_W +: SCORE_W] > best) begin
            best   = scores[i*SCORE_W +: SCORE_W];
            winner = 3'(i);
         end
      end
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (scores[i*SCORE_W +: SCORE_W] == best)
            n_top = n_top + 4'd1;
      end
      tie = (n_top > 4'd1);
   end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Parametrised game-flow controller for the button/pong family of VGA games. It owns the round state machine, per-player scores, the ball budget, the inter-ball rest timer, and winner resolution. It generalises the two-player controller to NUM_PLAYERS players and adds pause, start-press arming, score saturation and tie detection. It sits between the debounced keys, the graphics miss detectors and the text/graphics renderers, all in the 25 MHz pixel-clock domain.

Parameters:
NUM_PLAYERS, 2, number of players (2..8)
NUM_KEYS, 4, number of debounced start/control keys
SCORE_W, 3, score width per player
BALLS, 3, balls per game (1..2^BALL_W-1)
BALL_W, 3, width of balls_left
REST_TICKS, 120, frame ticks of rest after a miss or at game over (2 s at 60 Hz)
TMR_W, 8, rest-timer width; must hold REST_TICKS

Ports:
clk  in  1  pixel clock, 25 MHz
rst  in  1  asynchronous reset, active-high
key_n  in  NUM_KEYS  debounced keys, active-low; "press" = any bit low
pause_p  in  1  single-cycle pause toggle pulse
miss  in  NUM_PLAYERS  single-cycle miss pulses, bit i = player i missed
frame_tick  in  1  one-cycle pulse per frame (60 Hz)
state  out  3  0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 OVER, 4 PAUSED
stop  out  1  freeze ball/paddles; low only in PLAY
scores  out  NUM_PLAYERS*SCORE_W  packed scores, player 0 in LSBs
balls_left  out  BALL_W  balls remaining
winner  out  3  index of the top scorer
tie  out  1  two or more players share the top score
timer_busy  out  1  rest timer running

Behaviour:
- Reset (async, rst=1): state=NEWGAME, scores=0, balls_left=BALLS, timer=0, timer_busy=0, armed=0, stop=1. winner and tie are derived from the reset scores (winner=0, tie=1).
- All state, score, ball and timer registers update on the rising edge of clk. stop, winner and tie are combinational from the registered state and scores.
- Arming: the armed flag clears on every state entry. It sets on any cycle with all key_n high. A start press counts only when armed=1 and some key_n bit is 0. This prevents a held key from skipping states.
- NEWGAME: scores are held at 0 and balls_left at BALLS.
  - Armed press: balls_left <= BALLS-1, go to PLAY.
- PLAY (stop=0):
  - Any miss bit set: every player whose miss bit is 0 gains +1, saturating at 2^SCORE_W-1. If all bits are set, no score changes.
  - The rest timer loads REST_TICKS on the same edge.
  - If balls_left==0, go to OVER. Otherwise balls_left decrements and the next state is NEWBALL.
  - pause_p with no miss: go to PAUSED.
  - pause_p with a miss in the same cycle: the miss wins and pause_p is ignored.
- PAUSED (stop=1): scores and timer are frozen; miss is ignored. pause_p returns to PLAY.
- NEWBALL: go to PLAY when timer_busy=0 and there is an armed press. Presses during the rest interval are ignored.
- OVER: go to NEWGAME when timer_busy=0. No key is needed.
- Undefined state encodings: go to NEWGAME.
- Rest timer:
  - Loading REST_TICKS sets timer_busy=1.
  - It decrements by 1 on each frame_tick while nonzero.
  - timer_busy=0 from the cycle after the count reaches 0.
  - A load and a frame_tick in the same cycle: the load wins.
  - With REST_TICKS=0, timer_busy never asserts.
- Winner: the highest score, lowest index on equal scores. tie=1 if another player equals the maximum.
- The controller contains no clock divider or debouncer; those stay external.

Test Plan:
1. Reset with key_n held low, then release and press key 0 -> stays in NEWGAME until the release; after the press state=PLAY, balls_left=2, stop=0.
2. In PLAY pulse miss=2'b01 (NUM_PLAYERS=2) -> score1=1, score0=0, balls_left=1, state=NEWBALL, timer_busy=1; after 120 frame_ticks timer_busy=0; a press then returns to PLAY. A press at tick 60 is ignored.
3. Play to the last ball (balls_left=0) and pulse miss -> state=OVER, winner correct; after 120 ticks state=NEWGAME with scores cleared.
4. Pulse miss=2'b11 -> no score change, ball consumed. Drive one player to score 7 with SCORE_W=3 -> the score stays at 7 on a further win.
5. pause_p in PLAY -> PAUSED, stop=1, miss pulses ignored; pause_p again -> PLAY. pause_p and miss in the same cycle -> NEWBALL, not PAUSED.
6. NUM_PLAYERS=4, scores {2,5,5,1} -> winner=1, tie=1. Assert rst mid-NEWBALL -> state=NEWGAME, scores=0 and timer_busy=0 immediately, without waiting for a clock edge.
